// File: rtl/sram_wait_pkg.sv
// ============================================================================
// Module : sram_wait_pkg
// Brief  : Shared types and helpers for the wait-state SRAM block.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_wait_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_DATA_W = 32;
    localparam int BE_W       = DEF_DATA_W / 8;

    // Stored bit that makes the 9-bit lane word have an even number of ones.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_byte_array.sv
// ============================================================================
// Module : sram_byte_array
// Brief  : DEPTH x DATA_W storage, one synchronous port, per-lane write enables.
//          SRAM_PARITY_EN adds one even-parity bit per lane and a read check.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_byte_array
    import sram_wait_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = 17,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   be,
    input  logic                  inj_perr,
    output logic [DATA_W-1:0]     rdata,
    output logic                  perr
);

    localparam int c_BE_W = DATA_W / 8;

`ifdef SRAM_PARITY_EN
    logic [c_BE_W-1:0] w_lane_bad;
    assign perr = |w_lane_bad;
`else
    logic w_unused_inj;
    assign w_unused_inj = inj_perr;
    assign perr         = 1'b0;
`endif

    for (genvar i = 0; i < c_BE_W; i++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] r_byte;

        always_ff @(posedge clk) begin
            if (en && we && be[i]) mem[addr] <= wdata[8*i +: 8];
            if (en && !we)         r_byte    <= mem[addr];
        end
        assign rdata[8*i +: 8] = r_byte;

`ifdef SRAM_PARITY_EN
        logic par [DEPTH];
        logic r_bad;

        always_ff @(posedge clk) begin
            if (en && we && be[i]) par[addr] <= even_parity(wdata[8*i +: 8]) ^ inj_perr;
            if (en && !we)         r_bad     <= par[addr] ^ even_parity(mem[addr]);
        end
        assign w_lane_bad[i] = r_bad;
`endif
    end

endmodule

`default_nettype wire

// File: rtl/sram_wait_mem.sv
// ============================================================================
// Module : sram_wait_mem
// Brief  : Single-port SRAM with valid/ready request and fixed WAIT_CYCLES
//          latency. Optional parity via SRAM_PARITY_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_wait_mem
    import sram_wait_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = 17,
    parameter int DEPTH       = 2 ** ADDR_W,
    parameter int WAIT_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    input  logic                  inj_perr,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err
);

    localparam logic [ADDR_W:0] c_DEPTH    = (ADDR_W + 1)'(DEPTH);
    localparam logic [7:0]      c_CNT_LOAD = 8'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

    state_t              r_state;
    logic [7:0]          r_cnt;
    logic                r_resp_valid;
    logic                r_oor;
    logic                r_zero;
    logic                w_accept;
    logic                w_in_range;
    logic [DATA_W-1:0]   w_arr_rdata;
    logic                w_arr_perr;

    assign req_ready  = (r_state == IDLE);
    assign w_accept   = req_valid && req_ready;
    assign w_in_range = ({1'b0, req_addr} < c_DEPTH);

    sram_byte_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk      (clk),
        .en       (w_accept && w_in_range),
        .we       (req_we),
        .addr     (req_addr),
        .wdata    (req_wdata),
        .be       (req_be),
        .inj_perr (inj_perr),
        .rdata    (w_arr_rdata),
        .perr     (w_arr_perr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_resp_valid <= 1'b0;
            r_oor        <= 1'b0;
            r_zero       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_oor  <= !w_in_range;
                        r_zero <= req_we || !w_in_range;
                        r_cnt  <= c_CNT_LOAD;
                        if (WAIT_CYCLES == 0) begin
                            r_state      <= RESP;
                            r_resp_valid <= 1'b1;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == 8'd0) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                RESP: begin
                    r_state      <= IDLE;
                    r_resp_valid <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Array read register holds its data until RESP; writes and bad addresses read as zero.
    assign resp_valid = r_resp_valid;
    assign resp_rdata = (r_resp_valid && !r_zero) ? w_arr_rdata : '0;
    assign resp_err   = r_resp_valid && (r_oor || (!r_zero && w_arr_perr));

endmodule

`default_nettype wire

// File: tb/tb_sram_wait_mem.sv
// ============================================================================
// Module : tb_sram_wait_mem
// Brief  : Scoreboard bench: instance A (W=3, DEPTH=100), instance B (W=0).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_wait_mem;
    import sram_wait_pkg::*;

`ifdef SRAM_PARITY_EN
    localparam bit c_PAR = 1'b1;
`else
    localparam bit c_PAR = 1'b0;
`endif
    localparam int c_W_A = 3;
    localparam int c_W_B = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          due;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            valid_a = 1'b0;
    logic            valid_b = 1'b0;
    logic            we = 1'b0;
    logic [7:0]      addr = '0;
    logic [31:0]     wdata = '0;
    logic [BE_W-1:0] be = '0;
    logic            perr = 1'b0;
    logic            ready_a, ready_b, resp_valid_a, resp_valid_b, resp_err_a, resp_err_b;
    logic [31:0]     resp_rdata_a, resp_rdata_b;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    int   acc[4];
    int   dummy;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_wait_mem #(.DATA_W(32), .ADDR_W(8), .DEPTH(100), .WAIT_CYCLES(c_W_A)) u_dut_a (
        .clk(clk), .rst(rst), .req_valid(valid_a), .req_ready(ready_a), .req_we(we),
        .req_addr(addr), .req_wdata(wdata), .req_be(be), .inj_perr(perr),
        .resp_valid(resp_valid_a), .resp_rdata(resp_rdata_a), .resp_err(resp_err_a)
    );

    sram_wait_mem #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .WAIT_CYCLES(c_W_B)) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(valid_b), .req_ready(ready_b), .req_we(we),
        .req_addr(addr[3:0]), .req_wdata(wdata), .req_be(be), .inj_perr(perr),
        .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b), .resp_err(resp_err_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge right after the accept edge, valid still high.
    task automatic req(input bit sel, input bit w, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] b, input bit pe, input logic [31:0] exp_rd,
                       input bit exp_err, output int acc_cyc);
        exp_t e;
        int   k;
        we = w; addr = a; wdata = d; be = b; perr = pe;
        if (sel) valid_b = 1'b1; else valid_a = 1'b1;
        for (k = 0; k < 50; k++) begin
            if ((sel ? ready_b : ready_a) == 1'b1) break;
            @(negedge clk);
        end
        acc_cyc = cyc;
        if (k == 50) begin
            n_tests++; n_fail++;
            $display("FAIL req_timeout: got req_ready=0 for 50 cycles required 1");
            valid_a = 1'b0; valid_b = 1'b0;
        end else begin
            e.rd = exp_rd; e.err = exp_err;
            e.due = cyc + (sel ? c_W_B : c_W_A) + 1;
            if (sel) q_b.push_back(e); else q_a.push_back(e);
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        valid_a = 1'b0; valid_b = 1'b0; perr = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (resp_valid_a) begin
            if (q_a.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL a_unexpected_resp: got resp_valid=1 required 0 (nothing pending)");
            end else begin
                ea = q_a.pop_front();
                check("a_rdata", resp_rdata_a, ea.rd);
                check("a_err", 32'(resp_err_a), 32'(ea.err));
                check("a_latency_cycle", cyc, ea.due);
                check("a_ready_in_resp", 32'(ready_a), 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (resp_valid_b) begin
            if (q_b.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL b_unexpected_resp: got resp_valid=1 required 0 (nothing pending)");
            end else begin
                eb = q_b.pop_front();
                check("b_rdata", resp_rdata_b, eb.rd);
                check("b_err", 32'(resp_err_b), 32'(eb.err));
                check("b_latency_cycle", cyc, eb.due);
                check("b_ready_in_resp", 32'(ready_b), 32'd0);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_ready_a", 32'(ready_a), 32'd1);
        check("reset_ready_b", 32'(ready_b), 32'd1);
        check("reset_resp_valid_a", 32'(resp_valid_a), 32'd0);
        check("reset_rdata_a", resp_rdata_a, 32'd0);
        check("reset_err_a", 32'(resp_err_a), 32'd0);

        // Basic write then read, W=3
        req(0, 1, 8'd5, 32'hDEADBEEF, 4'hF, 0, 32'h0, 0, acc[0]);
        req(0, 0, 8'd5, 32'h0, 4'h0, 0, 32'hDEADBEEF, 0, acc[1]);
        check("a_peak_rate", 32'(acc[1] - acc[0]), 32'(c_W_A + 2));
        idle(6);

        // Byte lanes, including an all-zero enable write
        req(0, 1, 8'd7, 32'h11223344, 4'hF, 0, 32'h0, 0, dummy);
        req(0, 1, 8'd7, 32'hAABBCCDD, 4'h5, 0, 32'h0, 0, dummy);
        req(0, 1, 8'd7, 32'hFFFFFFFF, 4'h0, 0, 32'h0, 0, dummy);
        req(0, 0, 8'd7, 32'h0, 4'h0, 0, 32'h11BB33DD, 0, dummy);
        idle(6);

        // Range check at DEPTH=100
        req(0, 1, 8'd99, 32'h12345678, 4'hF, 0, 32'h0, 0, dummy);
        req(0, 1, 8'd100, 32'h00000005, 4'hF, 0, 32'h0, 1, dummy);
        req(0, 0, 8'd100, 32'h0, 4'h0, 0, 32'h0, 1, dummy);
        req(0, 0, 8'd255, 32'h0, 4'h0, 0, 32'h0, 1, dummy);
        req(0, 0, 8'd99, 32'h0, 4'h0, 0, 32'h12345678, 0, dummy);
        idle(6);

        // Reset while a read is waiting
        req(0, 1, 8'd2, 32'hCAFE0002, 4'hF, 0, 32'h0, 0, dummy);
        req(0, 0, 8'd2, 32'h0, 4'h0, 0, 32'hCAFE0002, 0, dummy);
        valid_a = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q_a.delete();
        check("mid_reset_ready_a", 32'(ready_a), 32'd1);
        check("mid_reset_no_resp", 32'(resp_valid_a), 32'd0);
        idle(8);
        req(0, 0, 8'd2, 32'h0, 4'h0, 0, 32'hCAFE0002, 0, dummy);
        idle(6);

        // W=0: fill then back-to-back reads with valid held high
        for (int i = 0; i < 4; i++)
            req(1, 1, 8'(i), 32'hB0000000 + 32'(i), 4'hF, 0, 32'h0, 0, dummy);
        for (int i = 0; i < 4; i++)
            req(1, 0, 8'(i), 32'h0, 4'h0, 0, 32'hB0000000 + 32'(i), 0, acc[i]);
        for (int i = 1; i < 4; i++)
            check("b_accept_spacing", 32'(acc[i] - acc[i-1]), 32'd2);
        idle(4);

        // Parity injection (error only reported when parity is built in)
        req(0, 1, 8'd9, 32'h0F0F0F0F, 4'hF, 1, 32'h0, 0, dummy);
        req(0, 0, 8'd9, 32'h0, 4'h0, 0, 32'h0F0F0F0F, c_PAR, dummy);
        req(0, 1, 8'd9, 32'h0F0F0F0F, 4'hF, 0, 32'h0, 0, dummy);
        req(0, 0, 8'd9, 32'h0, 4'h0, 0, 32'h0F0F0F0F, 0, dummy);
        idle(8);

        check("a_queue_drained", 32'(q_a.size()), 32'd0);
        check("b_queue_drained", 32'(q_b.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish by 200000 required finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
